// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm
// Purpose  : 8N1 UART receiver. Synchronises the asynchronous rx line,
//            detects a start edge, samples each bit at mid-bit and reports
//            each good byte with a one-cycle Done pulse. A stop bit sampled
//            low gives a one-cycle frame_err pulse and the byte is dropped.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            rx         - asynchronous serial input, idles high
//            dataout    - last correctly framed byte
//            Done       - pulse: dataout just updated
//            frame_err  - pulse: stop bit sampled low
//            busy       - high whenever a frame is being received
//            tick       - pulse on every bit-sample instant
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       Done,
    output logic       frame_err,
    output logic       busy,
    output logic       tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Start bit is checked half a bit in; every later bit one full bit apart.
    localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    dataout_q, dataout_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          w_fall;
    logic          w_tick;

    // Two-flop synchroniser plus one delay flop for edge detection. All reset
    // to the idle-line level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Only a genuine 1->0 transition starts a frame; a line stuck low is ignored.
    assign w_fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sh_q      <= 8'h00;
            dataout_q <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            dataout_q <= dataout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        sh_d      = sh_q;
        dataout_d = dataout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        w_tick    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_fall) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == c_HALF_LAST) begin
                    w_tick = 1'b1;
                    cnt_d  = '0;
                    if (!rx_s_q) begin
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end else begin
                        // Glitch shorter than half a bit: silently drop it.
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    w_tick = 1'b1;
                    cnt_d  = '0;
                    // LSB arrives first, so shifting in from the top leaves
                    // bit 0 at sh[0] after the eighth sample.
                    sh_d   = {rx_s_q, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    w_tick = 1'b1;
                    cnt_d  = '0;
                    if (rx_s_q) begin
                        dataout_d = sh_q;
                        done_d    = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                    end
                    // Leaving mid-stop-bit lets a back-to-back start edge be seen.
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dataout   = dataout_q;
    assign Done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
    assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fsm
// Purpose  : Self-checking bench for uart_rx_fsm. A timing model predicts,
//            from the rx pin history and the frame sample schedule, what
//            every output must be on each cycle; directed frames exercise
//            normal, back-to-back, false-start, framing-error and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    localparam int HSZ = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] dataout;
    logic       Done;
    logic       frame_err;
    logic       busy;
    logic       tick;

    always #20 clk = ~clk;

    uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .dataout   (dataout),
        .Done      (Done),
        .frame_err (frame_err),
        .busy      (busy),
        .tick      (tick)
    );

    int errors = 0;
    int checks = 0;

    // Pin history: hist[c] is the rx value captured at rising edge c.
    bit hist [0:HSZ-1];
    int n = -1;
    bit started = 1'b0;

    // Model state: a frame starts at cycle m_s; sample instants are fixed
    // offsets from it (start at H-1, then every CPB cycles).
    bit         m_active = 1'b0;
    int         m_s = 0;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_pend_data = 8'h00;
    bit         m_pend_done = 1'b0;
    bit         m_pend_ferr = 1'b0;

    logic [7:0] exp_data = 8'h00;
    bit         exp_done = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_tick = 1'b0;

    int         cnt_tick = 0;
    int         cnt_done = 0;
    int         cnt_ferr = 0;
    logic [7:0] got_q [$];

    function automatic bit hs(int c);
        if (c < 0) return 1'b1;
        return hist[c % HSZ];
    endfunction

    task automatic hset(int c);
        if (c >= 0) hist[c % HSZ] = 1'b1;
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, act, ex);
        end
    endtask

    // Model: predicts outputs for the cycle that follows this edge.
    always @(posedge clk) begin : p_model
        int o;
        int k;
        n++;
        started = 1'b1;
        hist[n % HSZ] = rx;
        if (reset) begin
            // Synchroniser flops reload the idle level on reset.
            hset(n); hset(n - 1); hset(n - 2);
            m_active    = 1'b0;
            m_pend_done = 1'b0;
            m_pend_ferr = 1'b0;
            m_data      = 8'h00;
            exp_data    = 8'h00;
            exp_done    = 1'b0;
            exp_ferr    = 1'b0;
            exp_busy    = 1'b0;
            exp_tick    = 1'b0;
        end else begin
            exp_done = m_pend_done;
            exp_ferr = m_pend_ferr;
            if (m_pend_done) m_data = m_pend_data;
            m_pend_done = 1'b0;
            m_pend_ferr = 1'b0;
            exp_data = m_data;
            exp_tick = 1'b0;
            exp_busy = 1'b0;
            if (m_active) begin
                o = n - m_s;
                exp_busy = 1'b1;
                if (o == H - 1) begin
                    exp_tick = 1'b1;
                    if (hs(n - 1)) m_active = 1'b0;
                end else if (o > H - 1 && ((o - (H - 1)) % CPB) == 0) begin
                    k = (o - (H - 1)) / CPB;
                    exp_tick = 1'b1;
                    if (k <= 8) begin
                        m_bits[k-1] = hs(n - 1);
                    end else begin
                        if (hs(n - 1)) begin
                            m_pend_done = 1'b1;
                            m_pend_data = m_bits;
                        end else begin
                            m_pend_ferr = 1'b1;
                        end
                        m_active = 1'b0;
                    end
                end
            end else if (hs(n - 2) && !hs(n - 1)) begin
                m_active = 1'b1;
                m_s = n + 1;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (started) begin
            cmp("tick",      {31'd0, tick},      {31'd0, exp_tick});
            cmp("busy",      {31'd0, busy},      {31'd0, exp_busy});
            cmp("Done",      {31'd0, Done},      {31'd0, exp_done});
            cmp("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
            cmp("dataout",   {24'd0, dataout},   {24'd0, exp_data});
            if (tick === 1'b1) cnt_tick++;
            if (Done === 1'b1) begin
                cnt_done++;
                got_q.push_back(dataout);
            end
            if (frame_err === 1'b1) cnt_ferr++;
        end
    end

    task automatic wait_cyc(int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(logic v, int c);
        rx = v;
        wait_cyc(c);
    endtask

    task automatic send(logic [7:0] d, logic stopv);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stopv, CPB);
    endtask

    task automatic clr();
        cnt_tick = 0;
        cnt_done = 0;
        cnt_ferr = 0;
        got_q.delete();
    endtask

    function automatic logic [7:0] got(int i);
        if (got_q.size() > i) return got_q[i];
        return 8'hxx;
    endfunction

    initial begin
        logic [7:0] f0;
        for (int i = 0; i < HSZ; i++) hist[i] = 1'b1;
        f0 = 8'hF0;

        reset = 1'b1;
        rx    = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        cmp("rst_dataout", {24'd0, dataout}, 32'h00);
        cmp("rst_busy",    {31'd0, busy},    32'd0);

        // Single frame
        clr();
        send(8'b10110011, 1'b1);
        wait_cyc(20);
        cmp("single_ticks", cnt_tick, 10);
        cmp("single_done",  cnt_done, 1);
        cmp("single_ferr",  cnt_ferr, 0);
        cmp("single_byte",  {24'd0, got(0)}, 32'hB3);
        cmp("single_busy",  {31'd0, busy},   32'd0);

        // Back-to-back frames, no idle gap
        clr();
        send(8'b11001100, 1'b1);
        send(8'b00000000, 1'b1);
        wait_cyc(20);
        cmp("b2b_done",  cnt_done, 2);
        cmp("b2b_ferr",  cnt_ferr, 0);
        cmp("b2b_byte0", {24'd0, got(0)}, 32'hCC);
        cmp("b2b_byte1", {24'd0, got(1)}, 32'h00);

        // False start
        clr();
        hold(1'b0, 4);
        hold(1'b1, 40);
        cmp("fs_ticks", cnt_tick, 1);
        cmp("fs_done",  cnt_done, 0);
        cmp("fs_ferr",  cnt_ferr, 0);
        cmp("fs_busy",  {31'd0, busy}, 32'd0);
        clr();
        send(8'hA5, 1'b1);
        wait_cyc(20);
        cmp("fs_next_done", cnt_done, 1);
        cmp("fs_next_byte", {24'd0, dataout}, 32'hA5);

        // Framing error followed by a long low line
        clr();
        send(8'h3C, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 20);
        cmp("fe_ferr",    cnt_ferr, 1);
        cmp("fe_done",    cnt_done, 0);
        cmp("fe_ticks",   cnt_tick, 10);
        cmp("fe_dataout", {24'd0, dataout}, 32'hA5);
        clr();
        send(8'h5A, 1'b1);
        wait_cyc(20);
        cmp("fe_next_done", cnt_done, 1);
        cmp("fe_next_byte", {24'd0, dataout}, 32'h5A);

        // Reset during data bit 4
        clr();
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(f0[i], CPB);
        rx = f0[4];
        wait_cyc(8);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        hold(1'b1, 100);
        cmp("rm_done",    cnt_done, 0);
        cmp("rm_ferr",    cnt_ferr, 0);
        cmp("rm_dataout", {24'd0, dataout}, 32'h00);
        cmp("rm_busy",    {31'd0, busy},    32'd0);
        clr();
        send(8'hF0, 1'b1);
        wait_cyc(20);
        cmp("rm_next_done", cnt_done, 1);
        cmp("rm_next_byte", {24'd0, dataout}, 32'hF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
